// File: rtl/serial_subtractor8b.sv
// serial_subtractor8b: bit-serial a - b - bin, LSB first, valid/ready handshakes; optional ovf output under SUB_OVF_EN
module serial_subtractor8b #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic             brw, d, brw_next, last;
    // one bit slice of the subtractor plus the completed-result view of the shift register
    always_comb begin
        d        = ra[0] ^ rb[0] ^ brw;
        brw_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw);
        sr_next  = {d, sr};
        last     = cnt == CW'(WIDTH - 1);
    end
    // handshake FSM and serial datapath; outputs only change on entry to DONE or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            sr        <= '0;
            cnt       <= '0;
            brw       <= 1'b0;
`ifdef SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra       <= a;
                    rb       <= b;
                    brw      <= bin;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    brw <= brw_next;
                    sr  <= sr_next[WIDTH-1:1];
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        diff      <= sr_next;
                        bout      <= brw_next;
`ifdef SUB_OVF_EN
                        ovf       <= brw ^ brw_next;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor8b.sv
// tb_serial_subtractor8b: directed self-checking bench for serial_subtractor8b (WIDTH=8)
module tb_serial_subtractor8b;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       bout;
`ifdef SUB_OVF_EN
    logic       ovf;
`endif
    int checks = 0;
    int failures = 0;

    serial_subtractor8b #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
`ifdef SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    // Stimulus only: waits for in_ready, presents operands for one accepting edge,
    // scrambles the inputs afterwards, and returns the edges until out_valid (-1 on timeout).
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xbin, output int lat);
        lat = -1;
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        a = xa; b = xb; bin = xbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~xa; b = ~xb; bin = ~xbin;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", diff); end
        checks++; if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", bout); end
    endtask

    task automatic test_basic();
        int lat;
        run_op(8'h5A, 8'h3C, 1'b0, lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        checks++; if (diff !== 8'h1E) begin failures++; $display("FAIL basic_diff got=%h exp=1e", diff); end
        checks++; if (bout !== 1'b0) begin failures++; $display("FAIL basic_bout got=%b exp=0", bout); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_busy_in_ready got=%b exp=0", in_ready); end
        release_result();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drop_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_idle_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_wrap();
        int lat;
        run_op(8'h00, 8'h01, 1'b0, lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL wrap_latency got=%0d exp=8", lat); end
        checks++; if (diff !== 8'hFF) begin failures++; $display("FAIL wrap_diff got=%h exp=ff", diff); end
        checks++; if (bout !== 1'b1) begin failures++; $display("FAIL wrap_bout got=%b exp=1", bout); end
        release_result();
    endtask

    task automatic test_borrow_chain();
        int lat;
        run_op(8'h10, 8'h0F, 1'b1, lat);
        checks++; if (diff !== 8'h00) begin failures++; $display("FAIL chain1_diff got=%h exp=00", diff); end
        checks++; if (bout !== 1'b0) begin failures++; $display("FAIL chain1_bout got=%b exp=0", bout); end
        release_result();
        run_op(8'h00, 8'hFF, 1'b1, lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL chain2_latency got=%0d exp=8", lat); end
        checks++; if (diff !== 8'h00) begin failures++; $display("FAIL chain2_diff got=%h exp=00", diff); end
        checks++; if (bout !== 1'b1) begin failures++; $display("FAIL chain2_bout got=%b exp=1", bout); end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        run_op(8'h33, 8'h44, 1'b0, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || diff !== 8'hEF || bout !== 1'b1 || in_ready !== 1'b0) bad++;
            in_valid = (i == 1); a = 8'h77; b = 8'h11; bin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
        checks++; if (diff !== 8'hEF || bout !== 1'b1) begin failures++; $display("FAIL bp_final got=%h/%b exp=ef/1", diff, bout); end
        release_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b/%b exp=0/1", out_valid, in_ready); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_no_ghost_op bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid();
        int bad;
        a = 8'h5A; b = 8'h3C; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (diff !== 8'h00 || bout !== 1'b0) begin failures++; $display("FAIL rstmid_result got=%h/%b exp=00/0", diff, bout); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_no_result bad_cycles=%0d exp=0", bad); end
    endtask

`ifdef SUB_OVF_EN
    task automatic test_ovf();
        int lat;
        run_op(8'h80, 8'h01, 1'b0, lat);
        checks++; if (diff !== 8'h7F || bout !== 1'b0) begin failures++; $display("FAIL ovf1_result got=%h/%b exp=7f/0", diff, bout); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf1_flag got=%b exp=1", ovf); end
        release_result();
        run_op(8'h05, 8'h03, 1'b0, lat);
        checks++; if (diff !== 8'h02) begin failures++; $display("FAIL ovf2_diff got=%h exp=02", diff); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf2_flag got=%b exp=0", ovf); end
        release_result();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_borrow_chain();
        test_backpressure();
        test_reset_mid();
`ifdef SUB_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
